segment_decoder: RTL and testbench



---
 rtl/segment_decoder.sv | 94 +++++++++
 tb/tb_segment_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_decoder.sv
// segment_decoder: synchronises an active-low gfedcba segment bus, waits for a
// pattern to stay stable, then decodes each newly accepted pattern to a hex digit.
module segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_an,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       blank_out,
    output logic       err_out,
    output logic       new_strobe
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] CNT_SAT   = 8'(STABLE_CYCLES - 1);

    logic [6:0] r_seg_p0;
    logic [6:0] r_seg_p1;
    logic [6:0] r_cand_p2;
    logic [7:0] r_cnt_p2;
    logic [6:0] r_acc;

    logic       w_changed;
    logic       w_eligible;
    logic [5:0] w_dec;

    // Returns {err, blank, digit} for one active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        logic [5:0] res;
        case (pat)
            7'h40:     res = {2'b00, 4'h0};
            7'h79:     res = {2'b00, 4'h1};
            7'h24:     res = {2'b00, 4'h2};
            7'h30:     res = {2'b00, 4'h3};
            7'h19:     res = {2'b00, 4'h4};
            7'h12:     res = {2'b00, 4'h5};
            7'h02:     res = {2'b00, 4'h6};
            7'h78:     res = {2'b00, 4'h7};
            7'h00:     res = {2'b00, 4'h8};
            7'h18:     res = {2'b00, 4'h9};
            7'h08:     res = {2'b00, 4'hA};
            7'h03:     res = {2'b00, 4'hB};
            7'h46:     res = {2'b00, 4'hC};
            7'h21:     res = {2'b00, 4'hD};
            7'h06:     res = {2'b00, 4'hE};
            7'h0E:     res = {2'b00, 4'hF};
            SEG_BLANK: res = {2'b01, 4'h0};
            default:   res = {2'b10, 4'h0};
        endcase
        return res;
    endfunction

    assign w_changed  = (r_seg_p1 != r_cand_p2);
    assign w_eligible = !w_changed && (r_cnt_p2 == CNT_SAT);
    assign w_dec      = decode_seg(r_cand_p2);

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_seg_p0   <= SEG_BLANK;
            r_seg_p1   <= SEG_BLANK;
            r_cand_p2  <= SEG_BLANK;
            r_cnt_p2   <= '0;
            r_acc      <= SEG_BLANK;
            digit_out  <= 4'h0;
            blank_out  <= 1'b1;
            err_out    <= 1'b0;
            new_strobe <= 1'b0;
        end else begin
            // p0/p1: two-flop synchroniser for the asynchronous segment lines
            r_seg_p0   <= seg_in;
            r_seg_p1   <= r_seg_p0;
            new_strobe <= 1'b0;

            // p2: stability filter; a change always restarts the count
            if (w_changed) begin
                r_cand_p2 <= r_seg_p1;
                r_cnt_p2  <= '0;
            end else if (r_cnt_p2 < CNT_SAT) begin
                r_cnt_p2 <= r_cnt_p2 + 8'd1;
            end

            // accept: only a stable pattern that differs from the last accepted one
            if (w_eligible && (r_cand_p2 != r_acc)) begin
                r_acc      <= r_cand_p2;
                digit_out  <= w_dec[3:0];
                blank_out  <= w_dec[4];
                err_out    <= w_dec[5];
                new_strobe <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segment_decoder.sv
// Bench for segment_decoder: three instances (STABLE_CYCLES 4, 1, 255) compared
// every cycle against a run-length reference model, plus directed scenario checks.
module tb_segment_decoder;

    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic [6:0] seg_in = 7'h7F;

    logic [3:0] d0, d1, d2;
    logic       b0, b1, b2, e0, e1, e2, s0, s1, s2;
    logic [6:0] obs [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    segment_decoder #(.STABLE_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_an(rst_an), .seg_in(seg_in),
        .digit_out(d0), .blank_out(b0), .err_out(e0), .new_strobe(s0));
    segment_decoder #(.STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_an(rst_an), .seg_in(seg_in),
        .digit_out(d1), .blank_out(b1), .err_out(e1), .new_strobe(s1));
    segment_decoder #(.STABLE_CYCLES(255)) u_dut2 (
        .clk(clk), .rst_an(rst_an), .seg_in(seg_in),
        .digit_out(d2), .blank_out(b2), .err_out(e2), .new_strobe(s2));

    assign obs[0] = {d0, b0, e0, s0};
    assign obs[1] = {d1, b1, e1, s1};
    assign obs[2] = {d2, b2, e2, s2};

    // Reference model: a pattern is accepted once the synchronised value has been
    // the same for STABLE_CYCLES+1 consecutive edges and differs from the last one.
    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         sc [3] = '{4, 1, 255};
    logic [6:0] m_s1 [3];
    logic [6:0] m_s2 [3];
    logic [6:0] m_acc [3];
    int         m_run [3];
    logic [3:0] m_dig [3];
    logic       m_bl [3];
    logic       m_er [3];
    logic       m_stb [3];

    function automatic logic [5:0] model_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (codes[i] == p) return {2'b00, 4'(i)};
        if (p == 7'h7F) return 6'b01_0000;
        return 6'b10_0000;
    endfunction

    always @(posedge clk or negedge rst_an) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_an) begin
                m_s1[k] <= 7'h7F; m_s2[k] <= 7'h7F; m_acc[k] <= 7'h7F; m_run[k] <= 2;
                m_dig[k] <= 4'h0; m_bl[k] <= 1'b1; m_er[k] <= 1'b0; m_stb[k] <= 1'b0;
            end else begin
                if (m_run[k] >= sc[k] + 1 && m_s2[k] != m_acc[k]) begin
                    m_acc[k] <= m_s2[k];
                    {m_er[k], m_bl[k], m_dig[k]} <= model_decode(m_s2[k]);
                    m_stb[k] <= 1'b1;
                end else begin
                    m_stb[k] <= 1'b0;
                end
                if (m_s1[k] == m_s2[k]) m_run[k] <= (m_run[k] < 1000) ? m_run[k] + 1 : m_run[k];
                else                    m_run[k] <= 1;
                m_s2[k] <= m_s1[k];
                m_s1[k] <= seg_in;
            end
        end
    end

    task automatic test_reset();
        int nstb = 0;
        seg_in = 7'h30;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL reset_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        n_chk++;
        if (d0 !== 4'h3) begin n_err++; $display("FAIL reset_pre_digit: got %h expected 3", d0); end
        #2 rst_an = 1'b0;
        #1;
        n_chk++;
        if ({d0, b0, e0, s0} !== 7'b0000_1_0_0) begin
            n_err++; $display("FAIL reset_async: got %b expected 0000100", {d0, b0, e0, s0});
        end
        @(negedge clk);
        @(negedge clk);
        seg_in = 7'h7F;
        rst_an = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s0) nstb++;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL reset_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        n_chk++;
        if (nstb != 0) begin n_err++; $display("FAIL reset_no_strobe: got %0d strobes expected 0", nstb); end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 16; i++) begin
            int nstb = 0;
            int sedge = -1;
            seg_in = codes[i];
            for (int e = 0; e < 10; e++) begin
                @(negedge clk);
                if (s0) begin nstb++; sedge = e; end
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                        n_err++;
                        $display("FAIL table_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                    end
                end
            end
            n_chk++;
            if (nstb != 1 || sedge != 6) begin
                n_err++; $display("FAIL table_strobe code %h: got %0d strobes at edge %0d expected 1 at edge 6", codes[i], nstb, sedge);
            end
            n_chk++;
            if ({d0, b0, e0} !== {4'(i), 2'b00}) begin
                n_err++; $display("FAIL table_digit code %h: got %b expected %b", codes[i], {d0, b0, e0}, {4'(i), 2'b00});
            end
        end
    endtask

    task automatic test_glitch();
        int nstb = 0;
        logic [6:0] pat [3] = '{7'h24, 7'h30, 7'h24};
        int         len [3] = '{10, 3, 10};
        for (int p = 0; p < 3; p++) begin
            seg_in = pat[p];
            for (int c = 0; c < len[p]; c++) begin
                @(negedge clk);
                if (p > 0 && s0) nstb++;
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                        n_err++;
                        $display("FAIL glitch_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                    end
                end
            end
        end
        n_chk++;
        if (nstb != 0 || d0 !== 4'h2) begin
            n_err++; $display("FAIL glitch_reject: got %0d strobes digit %h expected 0 strobes digit 2", nstb, d0);
        end
        nstb = 0;
        seg_in = 7'h30;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s0) nstb++;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL glitch_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        n_chk++;
        if (nstb != 1 || d0 !== 4'h3) begin
            n_err++; $display("FAIL glitch_accept: got %0d strobes digit %h expected 1 strobe digit 3", nstb, d0);
        end
    endtask

    task automatic test_illegal_blank();
        logic [6:0] pat [4] = '{7'h7E, 7'h7F, 7'h12, 7'h7F};
        int         len [4] = '{10, 10, 2, 10};
        logic [6:0] want [4] = '{7'b0000_0_1_0, 7'b0000_1_0_0, 7'b0000_1_0_0, 7'b0000_1_0_0};
        int         wstb [4] = '{1, 1, 0, 0};
        for (int p = 0; p < 4; p++) begin
            int nstb = 0;
            seg_in = pat[p];
            for (int c = 0; c < len[p]; c++) begin
                @(negedge clk);
                if (s0) nstb++;
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                        n_err++;
                        $display("FAIL illegal_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                    end
                end
            end
            n_chk++;
            if (nstb != wstb[p] || {d0, b0, e0, 1'b0} !== want[p]) begin
                n_err++; $display("FAIL illegal_blank step%0d: got %0d strobes flags %b expected %0d strobes flags %b", p, nstb, {d0, b0, e0}, wstb[p], want[p][6:1]);
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        int pre = 0;
        int sedge = -1;
        seg_in = 7'h12;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst_an = 1'b0;
            @(negedge clk);
            if (s0) pre++;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL midreset_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        rst_an = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (s0 && sedge < 0) sedge = e;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL midreset_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        n_chk++;
        if (pre != 0 || sedge != 6 || d0 !== 4'h5) begin
            n_err++; $display("FAIL midreset_latency: got pre=%0d edge=%0d digit=%h expected pre=0 edge=6 digit=5", pre, sedge, d0);
        end
    endtask

    task automatic test_param_sweep();
        int ed1 = -1;
        int ed2 = -1;
        seg_in = 7'h08;
        for (int e = 0; e < 265; e++) begin
            @(negedge clk);
            if (s1 && ed1 < 0) ed1 = e;
            if (s2 && ed2 < 0) ed2 = e;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                    n_err++;
                    $display("FAIL sweep_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                end
            end
        end
        n_chk++;
        if (ed1 != 3 || d1 !== 4'hA) begin
            n_err++; $display("FAIL sweep_sc1: got edge %0d digit %h expected edge 3 digit A", ed1, d1);
        end
        n_chk++;
        if (ed2 != 257 || d2 !== 4'hA) begin
            n_err++; $display("FAIL sweep_sc255: got edge %0d digit %h expected edge 257 digit A", ed2, d2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 90; n++) begin
            int sel = $urandom_range(0, 3);
            int hold = $urandom_range(1, 8);
            if (sel <= 1)      seg_in = codes[$urandom_range(0, 15)];
            else if (sel == 2) seg_in = 7'h7F;
            else               seg_in = 7'($urandom);
            if ($urandom_range(0, 24) == 0) rst_an = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                rst_an = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    n_chk++;
                    if (obs[k] !== {m_dig[k], m_bl[k], m_er[k], m_stb[k]}) begin
                        n_err++;
                        $display("FAIL random_model inst%0d @%0t: got %b expected %b", k, $time, obs[k], {m_dig[k], m_bl[k], m_er[k], m_stb[k]});
                    end
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (obs[k] !== 7'b0000_1_0_0) begin
                n_err++; $display("FAIL reset_state inst%0d: got %b expected 0000100", k, obs[k]);
            end
        end
        rst_an = 1'b1;
        test_reset();
        test_full_table();
        test_glitch();
        test_illegal_blank();
        test_reset_mid_filter();
        test_param_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
